// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes and sequencer state encoding.
package alu_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/addsub_digit.sv
// Combinational DIGIT-wide add/subtract slice; subtract inverts b_d and relies on cin=1 at the LSB digit.
module addsub_digit #(
    parameter int unsigned DIGIT = 1
) (
    input  logic [DIGIT-1:0] a_d,
    input  logic [DIGIT-1:0] b_d,
    input  logic             op,
    input  logic             cin,
    output logic [DIGIT-1:0] s_d,
    output logic             cout
);

    logic [DIGIT:0] w_sum;

    assign w_sum = {1'b0, a_d} + {1'b0, b_d ^ {DIGIT{op}}} + (DIGIT+1)'(cin);
    assign s_d   = w_sum[DIGIT-1:0];
    assign cout  = w_sum[DIGIT];

endmodule

// File: rtl/addsub_seq.sv
// Digit-serial two's-complement add/subtract unit with start/ready/done handshake and status flags.
module addsub_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic             borrow,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int unsigned NDIG  = WIDTH / DIGIT;
    localparam int unsigned CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    state_t             r_state;
    state_t             w_next_state;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_res;
    logic               r_op;
    logic               r_c;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_a_msb;
    logic               r_b_msb;
    logic [WIDTH-1:0]   r_y;
    logic               r_borrow;
    logic               r_ovf;
    logic               r_zero;
    logic               r_neg;
    logic               r_ready;
    logic               r_done;

    logic [DIGIT-1:0]   w_s_d;
    logic               w_cout;
    logic [WIDTH-1:0]   w_res_next;
    logic               w_accept;
    logic               w_last;

    assign w_accept = start && (r_state == S_IDLE);
    assign w_last   = (r_cnt == CNT_W'(NDIG - 1));

    addsub_digit #(.DIGIT(DIGIT)) u_digit (
        .a_d  (r_a_sh[DIGIT-1:0]),
        .b_d  (r_b_sh[DIGIT-1:0]),
        .op   (r_op),
        .cin  (r_c),
        .s_d  (w_s_d),
        .cout (w_cout)
    );

    // New digit enters the result register from the MSB end
    generate
        if (DIGIT == WIDTH) begin : g_single
            assign w_res_next = w_s_d;
        end else begin : g_multi
            assign w_res_next = {w_s_d, r_res[WIDTH-1:DIGIT]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_ready <= (w_next_state == S_IDLE);
            r_done  <= (w_next_state == S_DONE);
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start)  w_next_state = S_RUN;
            S_RUN:   if (w_last) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Operand/result shift registers and flag capture on the final digit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_res    <= '0;
            r_op     <= OP_ADD;
            r_c      <= 1'b0;
            r_cnt    <= '0;
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            r_y      <= '0;
            r_borrow <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
            r_neg    <= 1'b0;
        end else if (w_accept) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_op    <= op;
            r_c     <= op;
            r_cnt   <= '0;
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1];
        end else if (r_state == S_RUN) begin
            r_a_sh <= r_a_sh >> DIGIT;
            r_b_sh <= r_b_sh >> DIGIT;
            r_res  <= w_res_next;
            r_c    <= w_cout;
            r_cnt  <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_y      <= w_res_next;
                r_borrow <= w_cout ^ r_op;
                r_ovf    <= (r_a_msb == (r_b_msb ^ r_op)) && (w_res_next[WIDTH-1] != r_a_msb);
                r_zero   <= (w_res_next == '0);
                r_neg    <= w_res_next[WIDTH-1];
            end
        end
    end

    assign ready  = r_ready;
    assign done   = r_done;
    assign y      = r_y;
    assign borrow = r_borrow;
    assign ovf    = r_ovf;
    assign zero   = r_zero;
    assign neg    = r_neg;

endmodule

// File: tb/tb_addsub_seq.sv
// Directed checks of addsub_seq in three configurations: 4x1, 8x4 and 8x1 bits/digit.
module tb_addsub_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       op;
    logic [7:0] a, b;
    logic       st4, st84, st81;

    logic       rdy4, dn4, bo4, ov4, ze4, ng4;
    logic [3:0] y4;
    logic       rdy84, dn84, bo84, ov84, ze84, ng84;
    logic [7:0] y84;
    logic       rdy81, dn81, bo81, ov81, ze81, ng81;
    logic [7:0] y81;

    addsub_seq #(.WIDTH(4), .DIGIT(1)) u_4x1 (
        .clk(clk), .rst(rst), .start(st4), .op(op), .a(a[3:0]), .b(b[3:0]),
        .ready(rdy4), .done(dn4), .y(y4), .borrow(bo4), .ovf(ov4), .zero(ze4), .neg(ng4)
    );
    addsub_seq #(.WIDTH(8), .DIGIT(4)) u_8x4 (
        .clk(clk), .rst(rst), .start(st84), .op(op), .a(a), .b(b),
        .ready(rdy84), .done(dn84), .y(y84), .borrow(bo84), .ovf(ov84), .zero(ze84), .neg(ng84)
    );
    addsub_seq #(.WIDTH(8), .DIGIT(1)) u_8x1 (
        .clk(clk), .rst(rst), .start(st81), .op(op), .a(a), .b(b),
        .ready(rdy81), .done(dn81), .y(y81), .borrow(bo81), .ovf(ov81), .zero(ze81), .neg(ng81)
    );

    int         sel;
    logic       m_ready, m_done, m_borrow, m_ovf, m_zero, m_neg;
    logic [7:0] m_y;

    always_comb begin
        case (sel)
            0:       {m_ready, m_done, m_y, m_borrow, m_ovf, m_zero, m_neg} = {rdy4, dn4, 4'h0, y4, bo4, ov4, ze4, ng4};
            1:       {m_ready, m_done, m_y, m_borrow, m_ovf, m_zero, m_neg} = {rdy84, dn84, y84, bo84, ov84, ze84, ng84};
            default: {m_ready, m_done, m_y, m_borrow, m_ovf, m_zero, m_neg} = {rdy81, dn81, y81, bo81, ov81, ze81, ng81};
        endcase
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_start(input logic v);
        st4  = (sel == 0) ? v : 1'b0;
        st84 = (sel == 1) ? v : 1'b0;
        st81 = (sel == 2) ? v : 1'b0;
    endtask

    // Issue one op, scramble inputs during RUN, wait for done; then verify result and handshake timing
    task automatic run_op(input string tag, input logic o, input logic [7:0] aa, input logic [7:0] bb,
                          input int ndig, input logic [7:0] ey,
                          input logic eb, input logic eo, input logic ez, input logic en);
        int lat;
        int rdy_low;
        @(negedge clk);
        op = o; a = aa; b = bb;
        set_start(1'b1);
        @(posedge clk);
        lat = 0;
        rdy_low = 0;
        @(negedge clk);
        set_start(1'b0);
        a = 8'($urandom); b = 8'($urandom); op = ~o;
        if (!m_ready) rdy_low++;
        while (!m_done && lat < 50) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (!m_ready) rdy_low++;
        end
        check({tag, " latency"}, 32'(lat), 32'(ndig));
        check({tag, " y"}, 32'(m_y), 32'(ey));
        check({tag, " flags"}, 32'({m_borrow, m_ovf, m_zero, m_neg}), 32'({eb, eo, ez, en}));
        @(posedge clk);
        @(negedge clk);
        check({tag, " done width"}, 32'(m_done), 32'd0);
        check({tag, " ready back"}, 32'(m_ready), 32'd1);
        check({tag, " ready low cycles"}, 32'(rdy_low), 32'(ndig + 1));
        check({tag, " y hold"}, 32'(m_y), 32'(ey));
    endtask

    initial begin
        int dones;
        sel = 0;
        rst = 1'b1;
        op = 1'b0; a = '0; b = '0;
        st4 = 1'b0; st84 = 1'b0; st81 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset ready", 32'(m_ready), 32'd1);
        check("reset done", 32'(m_done), 32'd0);
        check("reset y", 32'(m_y), 32'd0);
        check("reset flags", 32'({m_borrow, m_ovf, m_zero, m_neg}), 32'd0);

        // 4-bit, 1 bit/cycle: subtract and add vectors (values are 4-bit, y zero-extended)
        sel = 0;
        run_op("t1 0001-0001", 1'b1, 8'h1, 8'h1, 4, 8'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op("t2 1010-0011", 1'b1, 8'hA, 8'h3, 4, 8'h7, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op("t2 1100-0101", 1'b1, 8'hC, 8'h5, 4, 8'h7, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op("t2 0101-1001", 1'b1, 8'h5, 8'h9, 4, 8'hC, 1'b1, 1'b1, 1'b0, 1'b1);
        run_op("t3 1111+0001", 1'b0, 8'hF, 8'h1, 4, 8'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        run_op("t3 0111+0001", 1'b0, 8'h7, 8'h1, 4, 8'h8, 1'b0, 1'b1, 1'b0, 1'b1);

        // 8-bit, 4 bits/cycle
        sel = 1;
        run_op("t4 80-01", 1'b1, 8'h80, 8'h01, 2, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op("t4 3C+C4", 1'b0, 8'h3C, 8'hC4, 2, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);

        // Handshake: busy-time start ignored, held start accepted once ready returns
        sel = 0;
        @(negedge clk);
        op = 1'b0; a = 8'h3; b = 8'h4;
        set_start(1'b1);
        @(posedge clk);
        @(negedge clk);
        set_start(1'b0);
        dones = 0;
        for (int n = 1; n <= 14; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (m_done) dones++;
            if (n == 4) check("t5 first done", 32'({m_done, m_y}), 32'({1'b1, 8'h7}));
            if (n >= 5 && n <= 9) check("t5 y holds first", 32'(m_y), 32'h7);
            if (n == 5) check("t5 ready after done", 32'(m_ready), 32'd1);
            if (n == 6) check("t5 second accepted", 32'(m_ready), 32'd0);
            if (n == 10) check("t5 second done", 32'({m_done, m_y}), 32'({1'b1, 8'h5}));
            if (n == 2) begin op = 1'b1; a = 8'h9; b = 8'h2; set_start(1'b1); end
            if (n == 3) set_start(1'b0);
            if (n == 4) begin op = 1'b1; a = 8'h6; b = 8'h1; set_start(1'b1); end
            if (n == 6) set_start(1'b0);
        end
        check("t5 done count", 32'(dones), 32'd2);

        // 8-bit serial: reset mid-RUN aborts the op
        sel = 2;
        run_op("t6 00-01", 1'b1, 8'h00, 8'h01, 8, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        op = 1'b0; a = 8'h55; b = 8'h11;
        set_start(1'b1);
        @(posedge clk);
        @(negedge clk);
        set_start(1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t6 busy before rst", 32'(m_ready), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("t6 rst y", 32'(m_y), 32'd0);
        check("t6 rst flags", 32'({m_borrow, m_ovf, m_zero, m_neg}), 32'd0);
        check("t6 rst done", 32'(m_done), 32'd0);
        check("t6 rst ready", 32'(m_ready), 32'd1);
        dones = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (m_done) dones++;
        end
        check("t6 no aborted done", 32'(dones), 32'd0);
        run_op("t6 7F+01", 1'b0, 8'h7F, 8'h01, 8, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
